// File: rtl/led_pattern_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer_pkg
// Description : Mode encodings, pattern start values and bounce direction
//               codes shared by the LED pattern sequencer blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pattern_sequencer_pkg;

    localparam int         c_mode_w      = 2;

    localparam logic [1:0] c_mode_off    = 2'd0;
    localparam logic [1:0] c_mode_blink  = 2'd1;
    localparam logic [1:0] c_mode_chase  = 2'd2;
    localparam logic [1:0] c_mode_bounce = 2'd3;

    localparam logic [7:0] c_pat_off     = 8'h00;
    localparam logic [7:0] c_pat_blink   = 8'hFF;
    localparam logic [7:0] c_pat_chase   = 8'h01;
    localparam logic [7:0] c_pat_bounce  = 8'h01;

    localparam logic       c_dir_up      = 1'b0;
    localparam logic       c_dir_down    = 1'b1;

    function automatic logic [7:0] start_pat(input logic [1:0] mode);
        logic [7:0] pat;
        case (mode)
            c_mode_blink:  pat = c_pat_blink;
            c_mode_chase:  pat = c_pat_chase;
            c_mode_bounce: pat = c_pat_bounce;
            default:       pat = c_pat_off;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : led_tick_prescaler
// Description : Pausable modulo-TICK_DIV counter producing a one-cycle TICK.
// Revision    : 1.0 - initial release
// ============================================================================
module led_tick_prescaler #(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic CLK50MHz,
    input  logic RST,
    input  logic PAUSE,
    output logic TICK
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK50MHz) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (!PAUSE) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Combinational so the sequencer can act in the same cycle the count wraps.
    assign TICK = (r_cnt == c_last) && !PAUSE;

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer
// Description : Animated LED patterns with step-aligned, queued mode changes.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 12500000,
    parameter int CNT_W    = 24
) (
    input  logic       CLK50MHz,
    input  logic       RST,
    input  logic [1:0] MODE_SEL,
    input  logic       MODE_LD,
    input  logic       PAUSE,
    output logic       BUSY,
    output logic       STEP_STB,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       LED4,
    output logic       LED5,
    output logic       LED6,
    output logic       LED7
);

    logic                w_tick;

    logic [c_mode_w-1:0] r_mode,      w_mode_nxt;
    logic                r_dir,       w_dir_nxt;
    logic [7:0]          r_pat,       w_pat_nxt;
    logic [c_mode_w-1:0] r_pend_mode, w_pend_mode_nxt;
    logic                r_pend_vld,  w_pend_vld_nxt;
    logic                r_step_stb;

    led_tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .CLK50MHz (CLK50MHz),
        .RST      (RST),
        .PAUSE    (PAUSE),
        .TICK     (w_tick)
    );

    always_ff @(posedge CLK50MHz) begin
        if (RST) begin
            r_mode      <= c_mode_off;
            r_dir       <= c_dir_up;
            r_pat       <= c_pat_off;
            r_pend_mode <= c_mode_off;
            r_pend_vld  <= 1'b0;
            r_step_stb  <= 1'b0;
        end else begin
            r_mode      <= w_mode_nxt;
            r_dir       <= w_dir_nxt;
            r_pat       <= w_pat_nxt;
            r_pend_mode <= w_pend_mode_nxt;
            r_pend_vld  <= w_pend_vld_nxt;
            r_step_stb  <= w_tick;
        end
    end

    always_comb begin
        w_mode_nxt      = r_mode;
        w_dir_nxt       = r_dir;
        w_pat_nxt       = r_pat;
        w_pend_mode_nxt = r_pend_mode;
        w_pend_vld_nxt  = r_pend_vld;

        if (w_tick) begin
            if (r_pend_vld) begin
                w_mode_nxt = r_pend_mode;
                w_pat_nxt  = start_pat(r_pend_mode);
                w_dir_nxt  = c_dir_up;
            end else begin
                case (r_mode)
                    c_mode_blink: w_pat_nxt = ~r_pat;
                    c_mode_chase: w_pat_nxt = {r_pat[6:0], r_pat[7]};
                    c_mode_bounce: begin
                        if (r_dir == c_dir_up) begin
                            if (r_pat == 8'h80) begin
                                w_pat_nxt = 8'h40;
                                w_dir_nxt = c_dir_down;
                            end else begin
                                w_pat_nxt = {r_pat[6:0], 1'b0};
                            end
                        end else begin
                            if (r_pat == 8'h01) begin
                                w_pat_nxt = 8'h02;
                                w_dir_nxt = c_dir_up;
                            end else begin
                                w_pat_nxt = {1'b0, r_pat[7:1]};
                            end
                        end
                    end
                    default: w_pat_nxt = c_pat_off;
                endcase
            end
        end

        // A load in the apply cycle re-arms the request rather than being lost.
        if (MODE_LD) begin
            w_pend_mode_nxt = MODE_SEL;
            w_pend_vld_nxt  = 1'b1;
        end else if (w_tick) begin
            w_pend_vld_nxt  = 1'b0;
        end
    end

    always_comb begin
        BUSY     = r_pend_vld;
        STEP_STB = r_step_stb;
        LED0     = r_pat[0];
        LED1     = r_pat[1];
        LED2     = r_pat[2];
        LED3     = r_pat[3];
        LED4     = r_pat[4];
        LED5     = r_pat[5];
        LED6     = r_pat[6];
        LED7     = r_pat[7];
    end

endmodule
`default_nettype wire
